// File: rtl/tick_rate_generator.sv
`timescale 1ns/1ps
// Programmable tick-enable generator: a base prescaler feeding an octave counter that
// gives tick periods of BASE_DIVISOR*2^s cycles. Define TICK_RATE_STEP_EN for single-step ticks.
module tick_rate_generator #(
  parameter int BASE_DIVISOR = 12500000,
  parameter int RATE_COUNT   = 4,
  parameter int SELECT_WIDTH = 2,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SELECT_WIDTH-1:0] rate_select,
  input  logic                    run,
  input  logic                    step,
  output logic                    tick,
  output logic [COUNT_WIDTH-1:0]  tick_count,
  output logic [SELECT_WIDTH-1:0] rate_active
);

  localparam int PRE_W = (BASE_DIVISOR > 2) ? $clog2(BASE_DIVISOR) : 1;
  localparam int OCT_W = (RATE_COUNT > 2) ? RATE_COUNT - 1 : 1;

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [OCT_W-1:0]        oct_q, oct_d;
  logic                    tick_q, tick_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [SELECT_WIDTH-1:0] rate_q, rate_d;
  logic                    fresh_q, fresh_d;

  logic [SELECT_WIDTH-1:0] sel_clamped;
  logic [SELECT_WIDTH-1:0] rate_eff;
  logic [OCT_W-1:0]        oct_mask;
  logic                    oct_match;
  logic                    base_strobe;
  logic                    free_tick;
  logic                    step_tick;

`ifdef TICK_RATE_STEP_EN
  logic step_q, step_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step_d;
  end
`else
  logic unused_step;
  assign unused_step = step;
`endif

  // fresh_q marks the first cycle after reset, where the rate still follows rate_select directly
  always_comb begin
    sel_clamped = rate_select;
    if ({1'b0, rate_select} >= (SELECT_WIDTH+1)'(RATE_COUNT))
      sel_clamped = SELECT_WIDTH'(RATE_COUNT - 1);

    rate_eff = fresh_q ? sel_clamped : rate_q;

    oct_mask = '0;
    for (int i = 0; i < OCT_W; i++) begin
      if (i < int'(rate_eff)) oct_mask[i] = 1'b1;
    end
    oct_match   = &(oct_q | ~oct_mask);
    base_strobe = run && (pre_q == PRE_W'(BASE_DIVISOR - 1));
    free_tick   = base_strobe && oct_match;

    pre_d = pre_q;
    if (run) pre_d = base_strobe ? '0 : pre_q + PRE_W'(1);

    oct_d = oct_q;
    if (free_tick)        oct_d = '0;
    else if (base_strobe) oct_d = oct_q + OCT_W'(1);

    step_tick = 1'b0;
`ifdef TICK_RATE_STEP_EN
    step_d    = step;
    step_tick = !run && step && !step_q;
`endif

    tick_d = free_tick || step_tick;

    count_d = count_q;
    if (tick_d) count_d = count_q + COUNT_WIDTH'(1);

    // Rate only switches on a tick boundary or while paused, so a period is never cut short
    rate_d  = (free_tick || !run) ? sel_clamped : rate_eff;
    fresh_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      oct_q   <= '0;
      tick_q  <= 1'b0;
      count_q <= '0;
      rate_q  <= '0;
      fresh_q <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      oct_q   <= oct_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      rate_q  <= rate_d;
      fresh_q <= fresh_d;
    end
  end

  assign tick        = tick_q;
  assign tick_count  = count_q;
  assign rate_active = rate_eff;

endmodule

// File: doc/tick_rate_generator.md
TICK_RATE_GENERATOR -- requirements
Module: tick_rate_generator

Interface
- REQ-001 SHALL have parameter BASE_DIVISOR, 12500000, clock cycles per fastest tick period (125 ms at 100 MHz); legal range is at least 2.
- REQ-002 SHALL have parameter RATE_COUNT, 4, number of selectable rates; each rate doubles the period of the previous one; legal range 1..2^SELECT_WIDTH.
- REQ-003 SHALL have parameter SELECT_WIDTH, 2, width of rate_select and rate_active.
- REQ-004 SHALL have parameter COUNT_WIDTH, 8, width of tick_count.
- REQ-005 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
- REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
- REQ-007 SHALL have port rate_select, input, SELECT_WIDTH, requested rate index s, with period = BASE_DIVISOR*2^s cycles.
- REQ-008 SHALL have port run, input, 1, 1 = free-running, 0 = paused.
- REQ-009 SHALL have port step, input, 1, single-step request, rising-edge sensitive.
- REQ-010 SHALL have port tick, output, 1, one-clock-wide enable pulse; this is an enable, not a derived clock.
- REQ-011 SHALL have port tick_count, output, COUNT_WIDTH, number of ticks issued, modulo 2^COUNT_WIDTH.
- REQ-012 SHALL have port rate_active, output, SELECT_WIDTH, the rate index currently in effect.

Function
- REQ-013 SHALL hold a prescaler that counts 0..BASE_DIVISOR-1 while run=1, wraps to 0, and asserts a base strobe on its wrap cycle.
- REQ-014 SHALL hold an octave counter of max(RATE_COUNT-1,1) bits that increments on each base strobe.
- REQ-015 SHALL assert tick for exactly one cycle on a base strobe when the low rate_active bits of the octave counter are all ones.
- REQ-016 SHALL, with run held at 1 and rate s constant, produce the first tick on clock edge N after reset release (N = BASE_DIVISOR*2^s) and then every N cycles.
- REQ-017 SHALL clamp any rate_select value at or above RATE_COUNT to RATE_COUNT-1.
- REQ-018 SHALL load the clamped rate_select into rate_active only on a cycle in which tick is asserted, or on any cycle while run=0; this makes rate switching glitch-free.
- REQ-019 SHALL clear the octave counter on every tick, so the new period starts phase-aligned to the tick.
- REQ-020 SHALL, while run=0, hold both the prescaler and the octave counter and issue no free-running ticks.
- REQ-021 SHALL, when run returns to 1, resume counting from the held values without an extra tick.
- REQ-022 SHALL register step and edge-detect it; a 0->1 transition sampled while run=0 SHALL produce one tick on the next cycle; a held-high step SHALL produce no further ticks.
- REQ-023 SHALL ignore step edges while run=1; a step tick SHALL NOT alter the prescaler or the octave counter.
- REQ-024 SHALL increment tick_count by 1 on every tick, free-running or step, and wrap from all-ones to 0.

Reset
- REQ-025 SHALL, while reset=1, force prescaler=0, octave counter=0, tick=0, tick_count=0, step edge register=0, and rate_active=clamped rate_select.
- REQ-026 SHALL abort any partial period when reset asserts mid-operation; no tick SHALL be issued during reset or on the cycle it deasserts.

Configuration
- REQ-027 SHALL implement the macro TICK_RATE_STEP_EN as follows:
  - defined: step logic per REQ-022..023 is compiled in;
  - undefined: step is ignored, the edge register is omitted, and ticks occur only while run=1.

Verification (BASE_DIVISOR=4, RATE_COUNT=4, SELECT_WIDTH=2, COUNT_WIDTH=8)
- REQ-028 SHALL cover: run=1, s=0, reset released -> ticks on edges 4, 8, 12; s=3 -> ticks every 32 cycles; tick_count increments once per tick.
- REQ-029 SHALL cover: s=0, change to s=2 mid-period -> the next tick is still at the s=0 boundary, the following ticks are spaced 16 cycles apart, and rate_active changes on the tick cycle.
- REQ-030 SHALL cover: run=0 for 20 cycles mid-period, then run=1 -> tick spacing extended by exactly 20 cycles, with no extra tick on resume.
- REQ-031 SHALL cover, with TICK_RATE_STEP_EN defined: run=0 and step pulsed 3 times -> 3 single-cycle ticks, tick_count +3; step held high 10 cycles -> 1 tick; step while run=1 -> no extra tick.
- REQ-032 SHALL cover: tick_count preloaded near 255 by 256 ticks -> wraps to 0; reset asserted mid-period -> all outputs cleared asynchronously and the first tick arrives 4 cycles after release.
